// File: rtl/data_port_responder_pkg.sv
// Shared encodings and constants for the CPU data-port responder.
// DATA_PORT_ALIGN_CHECK_EN adds the ERROR state used for misaligned-access rejection.
package data_port_responder_pkg;
    localparam int LEN        = 32;
    localparam int ADDR_WIDTH = 17;
    localparam int BYTE_SIZE  = 8;
    localparam int NUM_LANES  = LEN / BYTE_SIZE;

    typedef enum logic [1:0] {VIS_NONE = 2'b00, VIS_READ = 2'b01, VIS_WRITE = 2'b10, VIS_RSVD = 2'b11} vis_sig_e;
    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} vis_size_e;
    typedef enum logic [1:0] {STS_IDLE = 2'b00, STS_BUSY = 2'b01, STS_DONE = 2'b10, STS_ERR = 2'b11} vis_status_e;

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_READ_TAIL, S_WRITE, S_DONE
`ifdef DATA_PORT_ALIGN_CHECK_EN
        , S_ERROR
`endif
    } state_e;

    // Index of the final byte of an access (n-1).
    function automatic logic [1:0] last_idx(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 2'd0;
            SZ_HALF: return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == SZ_HALF && addr_lo[0]) || (size == SZ_WORD && addr_lo != 2'b00);
    endfunction
endpackage

// File: rtl/data_port_responder_if.sv
// CPU request/response and byte-bus signals of the data-port responder.
// slave = responder side, master = CPU + memory side.
interface data_port_responder_if;
    import data_port_responder_pkg::*;
    logic [ADDR_WIDTH-1:0] mem_data_addr;
    logic [LEN-1:0]        mem_write_data;
    logic [1:0]            memory_vis_signal;
    logic [1:0]            mem_vis_size;
    logic                  mem_sign_ext;
    logic [LEN-1:0]        mem_read_data;
    logic [1:0]            mem_vis_status;
    logic [ADDR_WIDTH-1:0] mem_vis_addr;
    logic [1:0]            mem_vis_signal;
    logic [BYTE_SIZE-1:0]  writen_data;
    logic [BYTE_SIZE-1:0]  mem_data;

    modport slave (
        input  mem_data_addr, mem_write_data, memory_vis_signal, mem_vis_size, mem_sign_ext, mem_data,
        output mem_read_data, mem_vis_status, mem_vis_addr, mem_vis_signal, writen_data
    );
    modport master (
        output mem_data_addr, mem_write_data, memory_vis_signal, mem_vis_size, mem_sign_ext, mem_data,
        input  mem_read_data, mem_vis_status, mem_vis_addr, mem_vis_signal, writen_data
    );
endinterface

// File: rtl/data_port_responder_load_align_ext.sv
// Combinational load formatter: byte lanes + size + sign_ext -> LEN-bit result.
module load_align_ext
    import data_port_responder_pkg::*;
(
    input  logic [NUM_LANES-1:0][BYTE_SIZE-1:0] i_lanes,
    input  logic [1:0]                          i_size,
    input  logic                                i_sign_ext,
    output logic [LEN-1:0]                      o_data
);
    logic w_msb;

    always_comb begin
        w_msb  = 1'b0;
        o_data = i_lanes;
        case (i_size)
            SZ_BYTE: begin
                w_msb  = i_sign_ext & i_lanes[0][BYTE_SIZE-1];
                o_data = {{(LEN-BYTE_SIZE){w_msb}}, i_lanes[0]};
            end
            SZ_HALF: begin
                w_msb  = i_sign_ext & i_lanes[1][BYTE_SIZE-1];
                o_data = {{(LEN-2*BYTE_SIZE){w_msb}}, i_lanes[1], i_lanes[0]};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/data_port_responder.sv
// Data-port responder: CPU word/half/byte loads and stores as little-endian byte-serial bus accesses.
// Define DATA_PORT_ALIGN_CHECK_EN to reject misaligned half/word accesses with a one-cycle error status.
module data_port_responder
    import data_port_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    data_port_responder_if.slave  bus
);
    state_e                             r_state, w_next;
    logic [ADDR_WIDTH-1:0]              r_base;
    logic [NUM_LANES-1:0][BYTE_SIZE-1:0] r_wdata, r_lanes, w_lanes;
    logic [LEN-1:0]                     r_rdata, w_ext;
    logic [1:0]                         r_size, r_cnt, w_cap_idx;
    logic                               r_sext, w_req_ok, w_cap;

    assign w_req_ok = (bus.memory_vis_signal == VIS_READ || bus.memory_vis_signal == VIS_WRITE)
                      && bus.mem_vis_size != SZ_RSVD;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_req_ok) begin
`ifdef DATA_PORT_ALIGN_CHECK_EN
                if (misaligned(bus.mem_vis_size, bus.mem_data_addr[1:0])) w_next = S_ERROR; else
`endif
                w_next = (bus.memory_vis_signal == VIS_READ) ? S_READ : S_WRITE;
            end
            S_READ:      if (r_cnt == last_idx(r_size)) w_next = S_READ_TAIL;
            S_READ_TAIL: w_next = S_DONE;
            S_WRITE:     if (r_cnt == last_idx(r_size)) w_next = S_DONE;
            S_DONE:      w_next = S_IDLE;
`ifdef DATA_PORT_ALIGN_CHECK_EN
            S_ERROR:     w_next = S_IDLE;
`endif
            default:     w_next = S_IDLE;
        endcase
    end

    // Read data lags its address by one cycle: READ cycle k returns byte k-1, READ_TAIL the last.
    always_comb begin
        w_cap     = 1'b0;
        w_cap_idx = r_cnt - 2'd1;
        w_lanes   = r_lanes;
        if (r_state == S_READ && r_cnt != 2'd0) begin
            w_cap = 1'b1;
        end else if (r_state == S_READ_TAIL) begin
            w_cap     = 1'b1;
            w_cap_idx = last_idx(r_size);
        end
        if (w_cap) w_lanes[w_cap_idx] = bus.mem_data;
    end

    load_align_ext u_ext (
        .i_lanes    (w_lanes),
        .i_size     (r_size),
        .i_sign_ext (r_sext),
        .o_data     (w_ext)
    );

    // The result is formatted from the tail byte directly so it is visible during DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base  <= '0;
            r_wdata <= '0;
            r_size  <= '0;
            r_sext  <= 1'b0;
            r_cnt   <= '0;
            r_lanes <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == S_IDLE && w_req_ok) begin
                r_base  <= bus.mem_data_addr;
                r_wdata <= bus.mem_write_data;
                r_size  <= bus.mem_vis_size;
                r_sext  <= bus.mem_sign_ext;
                r_cnt   <= '0;
            end else if (r_state == S_READ || r_state == S_WRITE) begin
                r_cnt <= r_cnt + 2'd1;
            end
            if (w_cap) r_lanes <= w_lanes;
            if (r_state == S_READ_TAIL) r_rdata <= w_ext;
        end
    end

    always_comb begin
        bus.mem_vis_status = STS_IDLE;
        bus.mem_vis_signal = VIS_NONE;
        bus.mem_vis_addr   = '0;
        bus.writen_data    = '0;
        case (r_state)
            S_READ: begin
                bus.mem_vis_status = STS_BUSY;
                bus.mem_vis_signal = VIS_READ;
                bus.mem_vis_addr   = r_base + ADDR_WIDTH'(r_cnt);
            end
            S_READ_TAIL: bus.mem_vis_status = STS_BUSY;
            S_WRITE: begin
                bus.mem_vis_status = STS_BUSY;
                bus.mem_vis_signal = VIS_WRITE;
                bus.mem_vis_addr   = r_base + ADDR_WIDTH'(r_cnt);
                bus.writen_data    = r_wdata[r_cnt];
            end
            S_DONE: bus.mem_vis_status = STS_DONE;
`ifdef DATA_PORT_ALIGN_CHECK_EN
            S_ERROR: bus.mem_vis_status = STS_ERR;
`endif
            default: ;
        endcase
    end

    assign bus.mem_read_data = r_rdata;
endmodule

// File: tb/tb_data_port_responder.sv
// Self-checking bench: directed vector table, reset/invalid sequences, random traffic vs a byte-array model.
module tb_data_port_responder;
    import data_port_responder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_port_responder_if bus();
    data_port_responder dut (.clk(clk), .rst(rst), .bus(bus));

    localparam int MEM_SZ = 1 << ADDR_WIDTH;
    logic [7:0] mem     [0:MEM_SZ-1];
    logic [7:0] ref_mem [0:MEM_SZ-1];
    logic [31:0] model_rd;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  sig;
        logic [1:0]  sz;
        logic        sx;
        logic [16:0] addr;
        logic [31:0] wd;
        bit          chk_rd;
        logic [31:0] exp;
    } vec_t;

    function automatic logic [7:0] pat(input logic [16:0] a);
        return a[7:0] ^ {a[16:13], a[12:9]} ^ 8'h3C;
    endfunction

    // Byte-addressed memory on the bus: write at the edge, read data one cycle after address.
    initial begin
        for (int i = 0; i < MEM_SZ; i++) mem[i] = pat(17'(i));
        bus.mem_data = 8'h00;
        forever begin
            @(posedge clk);
            if (bus.mem_vis_signal == 2'b10) mem[bus.mem_vis_addr] = bus.writen_data;
            bus.mem_data <= mem[bus.mem_vis_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [16:0] addr, input logic [1:0] sz, input logic sx);
        logic [31:0] v = 32'h0;
        int n = nbytes(sz);
        for (int k = 0; k < n; k++) v = v | (32'(ref_mem[addr + 17'(k)]) << (8 * k));
        if (sx && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
        return v;
    endfunction

    // Called at a falling edge in an IDLE cycle; returns at the falling edge of the following IDLE cycle.
    task automatic do_req(input logic [1:0] sig, input logic [1:0] sz, input logic sx,
                          input logic [16:0] addr, input logic [31:0] wd);
        int n = nbytes(sz);
        logic [16:0] a;
        logic [31:0] exp_ld = ref_load(addr, sz, sx);
        bus.memory_vis_signal = sig;
        bus.mem_vis_size      = sz;
        bus.mem_sign_ext      = sx;
        bus.mem_data_addr     = addr;
        bus.mem_write_data    = wd;
        @(posedge clk);
        @(negedge clk);
        bus.memory_vis_signal = 2'b00;
`ifdef DATA_PORT_ALIGN_CHECK_EN
        if ((sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00)) begin
            chk("err_status", 32'(bus.mem_vis_status), 32'd3);
            chk("err_no_bus", 32'(bus.mem_vis_signal), 32'd0);
            @(negedge clk);
            chk("err_then_idle", 32'(bus.mem_vis_status), 32'd0);
            chk("err_rdata_kept", bus.mem_read_data, model_rd);
            return;
        end
`endif
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            a = addr + 17'(k);
            chk("bus_sig", 32'(bus.mem_vis_signal), 32'(sig));
            chk("bus_addr", 32'(bus.mem_vis_addr), 32'(a));
            chk("busy", 32'(bus.mem_vis_status), 32'd1);
            if (sig == 2'b10) begin
                chk("bus_wbyte", 32'(bus.writen_data), 32'(wd[8*k +: 8]));
                ref_mem[a] = wd[8*k +: 8];
            end
        end
        if (sig == 2'b01) begin
            @(negedge clk);
            chk("tail_bus_idle", 32'(bus.mem_vis_signal), 32'd0);
            chk("tail_busy", 32'(bus.mem_vis_status), 32'd1);
            model_rd = exp_ld;
        end
        @(negedge clk);
        chk("done_status", 32'(bus.mem_vis_status), 32'd2);
        chk("done_rdata", bus.mem_read_data, model_rd);
        // A request during DONE must be ignored.
        bus.memory_vis_signal = 2'b01;
        bus.mem_vis_size      = 2'b00;
        @(negedge clk);
        bus.memory_vis_signal = 2'b00;
        chk("idle_after_done", 32'(bus.mem_vis_status), 32'd0);
        chk("idle_bus", 32'(bus.mem_vis_signal), 32'd0);
        chk("rdata_held", bus.mem_read_data, model_rd);
    endtask

    vec_t vecs[$];
    logic [31:0] exp_wrap;

    initial begin
        for (int i = 0; i < MEM_SZ; i++) ref_mem[i] = pat(17'(i));
        model_rd              = 32'h0;
        bus.memory_vis_signal = 2'b00;
        bus.mem_vis_size      = 2'b00;
        bus.mem_sign_ext      = 1'b0;
        bus.mem_data_addr     = '0;
        bus.mem_write_data    = '0;

`ifdef DATA_PORT_ALIGN_CHECK_EN
        exp_wrap = 32'h00008001;
`else
        exp_wrap = 32'h332211A5;
`endif
        vecs.push_back('{2'b10, 2'b10, 1'b0, 17'h00100, 32'hDEADBEEF, 1'b0, 32'h0});
        vecs.push_back('{2'b01, 2'b10, 1'b0, 17'h00100, 32'h0,        1'b1, 32'hDEADBEEF});
        vecs.push_back('{2'b01, 2'b00, 1'b1, 17'h00101, 32'h0,        1'b1, 32'hFFFFFFBE});
        vecs.push_back('{2'b01, 2'b00, 1'b0, 17'h00101, 32'h0,        1'b1, 32'h000000BE});
        vecs.push_back('{2'b10, 2'b01, 1'b0, 17'h00200, 32'h00008001, 1'b0, 32'h0});
        vecs.push_back('{2'b01, 2'b01, 1'b1, 17'h00200, 32'h0,        1'b1, 32'hFFFF8001});
        vecs.push_back('{2'b01, 2'b01, 1'b0, 17'h00200, 32'h0,        1'b1, 32'h00008001});
        vecs.push_back('{2'b10, 2'b00, 1'b0, 17'h1FFFF, 32'h123456A5, 1'b0, 32'h0});
        vecs.push_back('{2'b10, 2'b10, 1'b0, 17'h00000, 32'h44332211, 1'b0, 32'h0});
        vecs.push_back('{2'b01, 2'b10, 1'b0, 17'h1FFFF, 32'h0,        1'b1, exp_wrap});

        @(negedge clk);
        @(negedge clk);
        chk("rst_status", 32'(bus.mem_vis_status), 32'd0);
        chk("rst_rdata", bus.mem_read_data, 32'd0);
        chk("rst_addr", 32'(bus.mem_vis_addr), 32'd0);
        chk("rst_sig", 32'(bus.mem_vis_signal), 32'd0);
        chk("rst_wdata", 32'(bus.writen_data), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_req(vecs[i].sig, vecs[i].sz, vecs[i].sx, vecs[i].addr, vecs[i].wd);
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), bus.mem_read_data, vecs[i].exp);
        end

        // Reserved encodings are ignored.
        for (int j = 0; j < 3; j++) begin
            bus.memory_vis_signal = (j == 0) ? 2'b11 : (j == 1) ? 2'b01 : 2'b10;
            bus.mem_vis_size      = (j == 0) ? 2'b10 : 2'b11;
            bus.mem_data_addr     = 17'h00100;
            @(negedge clk);
            chk("inv_status", 32'(bus.mem_vis_status), 32'd0);
            chk("inv_bus", 32'(bus.mem_vis_signal), 32'd0);
        end
        bus.memory_vis_signal = 2'b00;
        @(negedge clk);
        chk("inv_idle", 32'(bus.mem_vis_status), 32'd0);

        // Reset in the third byte of a word store.
        bus.memory_vis_signal = 2'b10;
        bus.mem_vis_size      = 2'b10;
        bus.mem_data_addr     = 17'h00300;
        bus.mem_write_data    = 32'h11223344;
        @(posedge clk);
        @(negedge clk);
        bus.memory_vis_signal = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_byte2_addr", 32'(bus.mem_vis_addr), 32'h00302);
        #1 rst = 1'b0;
        #1;
        chk("rstmid_status", 32'(bus.mem_vis_status), 32'd0);
        chk("rstmid_sig", 32'(bus.mem_vis_signal), 32'd0);
        chk("rstmid_addr", 32'(bus.mem_vis_addr), 32'd0);
        chk("rstmid_wdata", 32'(bus.writen_data), 32'd0);
        chk("rstmid_rdata", bus.mem_read_data, 32'd0);
        ref_mem[17'h00300] = 8'h44;
        ref_mem[17'h00301] = 8'h33;
        model_rd = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_req(2'b01, 2'b10, 1'b0, 17'h00300, 32'h0);
        chk("rstmid_partial", bus.mem_read_data, {pat(17'h00303), pat(17'h00302), 8'h33, 8'h44});

        // Random traffic in small windows so loads revisit stored bytes, including the wrap region.
        for (int i = 0; i < 60; i++) begin
            logic [16:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? 17'(17'h1FFFC + 17'($urandom_range(0, 3)))
                                             : 17'($urandom_range(0, 31));
            do_req($urandom_range(0, 1) ? 2'b01 : 2'b10, 2'($urandom_range(0, 2)),
                   1'($urandom_range(0, 1)), ra, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_port_responder.md
# data_port_responder

Responder for the CPU's data-access port: accepts word/half/byte load and store requests from the CPU, executes them as little-endian byte-serial accesses on the main-memory byte bus, and returns the assembled and extended load result with a done status. It sits between the CPU data port and the main memory, parallel to the instruction cache, as the data-side counterpart of the CPU initiator.

## Interface
- LEN, 32, data word width
- ADDR_WIDTH, 17, byte address width
- BYTE_SIZE, 8, memory bus data width

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mem_data_addr  in  ADDR_WIDTH  request byte address
- mem_write_data  in  LEN  store data; low bytes used for byte/half
- memory_vis_signal  in  2  00 none, 01 load, 10 store, 11 reserved (ignored)
- mem_vis_size  in  2  00 byte, 01 half, 10 word, 11 reserved (request ignored)
- mem_sign_ext  in  1  1 = sign-extend load result, 0 = zero-extend
- mem_read_data  out  LEN  load result, held until next accepted load
- mem_vis_status  out  2  00 idle, 01 busy, 10 done, 11 error
- mem_vis_addr  out  ADDR_WIDTH  byte bus address
- mem_vis_signal  out  2  00 none, 01 read, 10 write
- writen_data  out  BYTE_SIZE  byte to write
- mem_data  in  BYTE_SIZE  read byte, valid one cycle after its address

## Operation
- FSM states: IDLE, READ, READ_TAIL, WRITE, DONE (+ ERROR under macro).
- IDLE: a valid request (signal 01/10, size 00/01/10) is accepted at the clock edge; address, data, size, sign_ext latched. Invalid encodings are ignored, state stays IDLE.
- n = 1/2/4 bytes. Byte k uses address (addr + k) mod 2^ADDR_WIDTH; byte k is bits [8k+7:8k].
- READ: n cycles driving mem_vis_signal 01, address addr+k; byte k captured on the edge ending the following cycle. READ_TAIL: bus 00, captures last byte. Then DONE.
- WRITE: n cycles driving mem_vis_signal 10, writen_data = byte k of latched data. Then DONE.
- DONE: one cycle, status 10; mem_read_data updated with extended result (loads only; stores leave it unchanged). Request inputs ignored in DONE; returns to IDLE.
- Extension: byte → bit 7, half → bit 15 replicated when mem_sign_ext, else zeros.
- Status 01 in every non-IDLE, non-DONE state.

## Timing
- Request sampled at end of cycle T. Load: bus active T+1..T+n, done at T+n+2 (word load: T+6). Store: bus active T+1..T+n, done at T+n+1 (word store: T+5).
- CPU must deassert or replace its request by the cycle after done; a request present in that IDLE cycle is a new request.
- Back-to-back: minimum one IDLE cycle between DONE and next bus activity.
- Reset (asynchronous, any state): FSM → IDLE; mem_read_data 0, mem_vis_status 00, mem_vis_addr 0, mem_vis_signal 00, writen_data 0. Bytes already written by an interrupted store remain in memory.
- Address wrap: 0x1FFFF word access touches 0x1FFFF, 0x00000, 0x00001, 0x00002.

## Configuration
- DATA_PORT_ALIGN_CHECK_EN defined: half at odd address or word at address not multiple of 4 → no bus activity, ERROR state for one cycle at T+1 (status 11), mem_read_data unchanged, then IDLE.
- Not defined: misaligned accesses execute bytewise as normal; status 11 never produced.

## Structure
- Shared package: vis_signal encodings (none/read/write), size encodings, status encodings (idle/busy/done/error), FSM state type, BYTE_SIZE constant.
- One sub-module: load_align_ext — combinational; collects byte-lane register, size, sign_ext → LEN-bit result.

## Test plan
- Store word 0xDEADBEEF at 0x00100, then load word → bus writes EF,BE,AD,DE at 0x100..0x103; load done at T+6 with 0xDEADBEEF.
- Load byte at 0x00101 (0xBE) with sign_ext=1 → 0xFFFFFFBE; with sign_ext=0 → 0x000000BE.
- Store half 0x8001 at 0x00200, load half sign-extended → 0xFFFF8001, done at T+4.
- Word load at 0x1FFFF → addresses 0x1FFFF,0x00000,0x00001,0x00002; with DATA_PORT_ALIGN_CHECK_EN → status 11 at T+1, no bus activity.
- Assert rst low during third byte of word store → all outputs 0 immediately; only first two bytes modified; next load works normally.
- memory_vis_signal 11 or mem_vis_size 11 → status stays 00, no bus activity.
